// File: rtl/mm_result_reader_if.sv
// Product-RAM read port plus the valid/ready result stream for the MM result reader.
// master = reader side, slave = RAM/consumer side.
interface mm_result_reader_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 4
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, out_data, out_valid, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/mm_result_reader.sv
// Streams product RAM words 0..N_RESULTS-1 out on valid/ready after a start pulse.
// Reads are throttled so buffered plus in-flight words never exceed the 3-entry FIFO.
module mm_result_reader #(
  parameter int DATA_W    = 18,
  parameter int ADDR_W    = 4,
  parameter int N_RESULTS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  mm_result_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_RESULTS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] hs_cnt_reg;
  logic              inflight_reg;
  logic              done_reg;
  logic [DATA_W-1:0] fifo_mem [0:2];
  logic [1:0]        wr_ptr_reg, rd_ptr_reg, occ_reg;
  logic              issue, push, pop, hs_last, fifo_nonempty;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue decision uses only registered occupancy, never out_ready.
  assign issue         = (state_reg == READ) &&
                         (({1'b0, occ_reg} + {2'b00, inflight_reg}) < 3'd3);
  assign push          = inflight_reg;
  assign fifo_nonempty = (occ_reg != 2'd0);
  assign pop           = fifo_nonempty && bus.out_ready;
  assign hs_last       = pop && (hs_cnt_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = READ;
      READ:    if (issue && (addr_reg == LAST_IDX)) state_next = DRAIN;
      DRAIN:   if (hs_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_reg != IDLE);
    done          = done_reg;
    bus.rd_en     = issue;
    bus.rd_addr   = addr_reg;
    bus.out_valid = fifo_nonempty;
    bus.out_data  = fifo_nonempty ? fifo_mem[rd_ptr_reg] : '0;
    bus.out_last  = fifo_nonempty && (hs_cnt_reg == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg     <= '0;
      hs_cnt_reg   <= '0;
      inflight_reg <= 1'b0;
      done_reg     <= 1'b0;
      wr_ptr_reg   <= 2'd0;
      rd_ptr_reg   <= 2'd0;
      occ_reg      <= 2'd0;
    end else begin
      inflight_reg <= issue;
      done_reg     <= (state_reg == DRAIN) && hs_last;
      if (state_reg == IDLE && start) begin
        addr_reg   <= '0;
        hs_cnt_reg <= '0;
      end else begin
        // Address parks on the last index so it never wraps within a read-out.
        if (issue && (addr_reg != LAST_IDX)) addr_reg <= addr_reg + 1'b1;
        if (pop && !hs_last) hs_cnt_reg <= hs_cnt_reg + 1'b1;
      end
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= bus.rd_data;
  end
endmodule

// File: doc/mm_result_reader.md
Name: mm_result_reader

Overview:
Read-out engine for the matrix-multiply product memory. After the MM controller has written all N_RESULTS product words, a start pulse makes this block read the product RAM at addresses 0..N_RESULTS-1 in order. It streams the words out on a valid/ready interface with full backpressure support. It sits between the product RAM read port and the downstream result consumer (serializer/host interface).

Parameters:
DATA_W, 18, width of one product word (RAM data and stream data)
ADDR_W, 4, product RAM address width
N_RESULTS, 16, number of words read per start; 1 <= N_RESULTS <= 2**ADDR_W

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a read-out; sampled only in IDLE
rd_en  out  1  product RAM read enable
rd_addr  out  ADDR_W  product RAM read address
rd_data  in  DATA_W  RAM read data, valid the cycle after rd_en (registered RAM, latency 1)
out_data  out  DATA_W  stream data
out_valid  out  1  stream data valid
out_ready  in  1  downstream ready
out_last  out  1  high with out_valid on word N_RESULTS-1
busy  out  1  high from the cycle after start is accepted through the final handshake cycle
done  out  1  one-cycle pulse the cycle after the final handshake

Behaviour:
- Reset: clk and rst (synchronous, active-high) as decided. All outputs 0: rd_en, rd_addr, out_valid, out_data, out_last, busy, done. State IDLE, counters 0, buffer empty, in-flight flag 0.
- States:
  - IDLE: start=1 -> READ.
  - READ: issues reads. After the read of address N_RESULTS-1 is issued -> DRAIN.
  - DRAIN: waits until the buffer is empty and the final handshake has occurred -> IDLE, with done=1 for 1 cycle.
- Read issue:
  - rd_en=1 in READ when (buffer occupancy + in-flight reads) < 3. The 3-entry output FIFO is internal and fixed.
  - rd_en depends only on registered state; no combinational path from out_ready to rd_en.
  - rd_addr increments by 1 per issued read, starting at 0. rd_addr holds its value when rd_en=0.
- Capture: a read issued in cycle k pushes rd_data into the FIFO at the end of cycle k+1.
- Output:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A handshake is a cycle with out_valid & out_ready; the FIFO pops on it.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable. out_valid never drops without a handshake.
- Latency: start sampled at edge of cycle 0 -> rd_en with addr 0 in cycle 1 -> out_valid with word 0 in cycle 3.
- Throughput: with out_ready held high, one word per cycle with no bubbles.
- Word count: a handshake counter counts 0..N_RESULTS-1. out_last = out_valid && count == N_RESULTS-1.
- busy: 1 from cycle 1 through the cycle of the final handshake.
- Boundaries:
  - start while busy: ignored, no restart.
  - start in the same cycle as done: accepted (done cycle is IDLE).
  - N_RESULTS=1: single word, out_last on it.
  - Address never exceeds N_RESULTS-1; no wrap within one read-out.
  - rd_data is ignored in cycles not following rd_en.
  - rst mid-operation: immediate return to reset values; FIFO flushed; data from a read issued in the reset cycle is discarded; no done pulse.

Test Plan:
- RAM preloaded with word i = 100+i, out_ready=1, start pulse in cycle 0 -> rd_en cycles 1..16 with addr 0..15; out_data 100..115 in cycles 3..18; out_last only in cycle 18; done in cycle 19; busy cycles 1..18.
- Same preload, out_ready low cycles 3..10 -> out_data holds 100 while stalled; rd_en stops after 3 outstanding; rd_addr holds 3; all 16 words delivered in order with no drops or duplicates.
- Random out_ready (50%), 3 back-to-back read-outs, each start given in the done cycle -> 48 words in order; out_last count=3; done count=3.
- start pulsed again in cycles 5 and 10 of an active read-out -> ignored; exactly 16 words and 1 done.
- rst asserted in cycle 8 with out_ready=0 -> next cycle all outputs 0; new start yields a full read-out beginning at addr 0 with word 100; no stale words emitted.
- N_RESULTS=1 build, out_ready=1 -> one word, out_valid=out_last=1 in cycle 3, done in cycle 4.
